urv_exception_unit: RTL and testbench

//  Machine-mode trap/interrupt controller feeding urv_csr. Owns mstatus, mie, mip, mepc, mcause and mtvec.

---
 rtl/urv_exception_unit_pkg.sv | 36 +++
 rtl/urv_exception_unit_irq_sync.sv | 42 ++++
 rtl/urv_exception_unit.sv | 155 +++++++++++++++
 tb/tb_urv_exception_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_exception_unit_pkg.sv
// Shared CSR addresses, cause codes and bit positions for the machine-mode trap controller.
// Pure constants and types: no latency, no flow control.
package urv_exception_unit_pkg;

    localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ID_MIE     = 12'h304;
    localparam logic [11:0] CSR_ID_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ID_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_ID_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_MISALIGN  = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
    localparam logic [3:0] CAUSE_ECALL     = 4'd11;
    localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;
    localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    // MPP is hard-wired to machine mode
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } exc_state_t;

    function automatic logic [31:0] mcause_value(input logic is_irq, input logic [3:0] code);
        return {is_irq, 27'b0, code};
    endfunction

endpackage

// File: rtl/urv_exception_unit_irq_sync.sv
// Interrupt source conditioning: timer tick latch (MTIP) and external level (MEIP); MTIP is 1 cycle after the tick.
// URV_EXT_IRQ_SYNC_EN adds a 2-flop synchronizer on irq_ext_i (MEIP lags 2 cycles), otherwise MEIP is combinational.
module urv_exception_unit_irq_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_ext_i,
    input  logic timer_tick_i,
    input  logic mti_taken_i,
    output logic meip,
    output logic mtip
);

    logic timer_latch;

    // A new tick arriving while the previous one is being taken must not be lost
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            timer_latch <= 1'b0;
        end else begin
            timer_latch <= timer_tick_i | (timer_latch & ~mti_taken_i);
        end
    end

    assign mtip = timer_latch;

`ifdef URV_EXT_IRQ_SYNC_EN
    logic [1:0] ext_sync;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ext_sync <= 2'b00;
        end else begin
            ext_sync <= {ext_sync[0], irq_ext_i};
        end
    end

    assign meip = ext_sync[1];
`else
    assign meip = irq_ext_i;
`endif

endmodule

// File: rtl/urv_exception_unit.sv
// Machine-mode trap/interrupt controller: owns mstatus/mie/mip/mepc/mcause/mtvec; trap and mret decisions are same-cycle.
// Nothing commits while X is stalled or killed; URV_EXT_IRQ_SYNC_EN enables the external interrupt synchronizer.
module urv_exception_unit
    import urv_exception_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET    = 32'h0000_0008,
    parameter int          HOLDOFF_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        x_valid_i,
    input  logic [31:0] x_pc_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic        d_is_csr_i,
    input  logic [11:0] d_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        d_is_mret_i,
    input  logic        irq_ext_i,
    input  logic        timer_tick_i,
    output logic        x_trap_o,
    output logic        x_mret_o,
    output logic [31:0] x_redirect_pc_o,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o,
    output logic [31:0] csr_mtvec_o
);

    localparam logic [2:0]  HOLDOFF_INIT = 3'(HOLDOFF_CYCLES);
    localparam logic [31:0] ADDR_MASK    = 32'hFFFF_FFFC;

    exc_state_t  state;
    logic [2:0]  hold_cnt;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_mtie;
    logic        mie_meie;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtvec;

    logic        meip;
    logic        mtip;
    logic        commit;
    logic        ext_active;
    logic        timer_active;
    logic        irq_pend;
    logic        mti_taken;
    logic        csr_write;
    logic [31:0] trap_cause;

    urv_exception_unit_irq_sync u_irq_sync (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .irq_ext_i    (irq_ext_i),
        .timer_tick_i (timer_tick_i),
        .mti_taken_i  (mti_taken),
        .meip         (meip),
        .mtip         (mtip)
    );

    assign commit       = x_valid_i & ~x_stall_i & ~x_kill_i;
    assign ext_active   = meip & mie_meie;
    assign timer_active = mtip & mie_mtie;
    assign irq_pend     = mstatus_mie & (ext_active | timer_active) & (state == ST_RUN);

    assign x_trap_o  = commit & (x_exception_i | irq_pend);
    assign x_mret_o  = commit & d_is_mret_i & ~x_trap_o;
    assign csr_write = commit & d_is_csr_i & ~x_trap_o;

    // Exception wins over interrupt, external wins over timer
    assign mti_taken  = x_trap_o & ~x_exception_i & ~ext_active;
    assign trap_cause = x_exception_i ? mcause_value(1'b0, x_exception_cause_i)
                      : ext_active    ? mcause_value(1'b1, CAUSE_IRQ_EXT)
                      :                 mcause_value(1'b1, CAUSE_IRQ_TIMER);

    assign x_redirect_pc_o = x_trap_o ? mtvec : mepc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= ST_RUN;
            hold_cnt <= 3'd0;
        end else if (x_trap_o || x_mret_o) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLDOFF_INIT;
        end else if (state == ST_HOLD) begin
            if (hold_cnt <= 3'd1) begin
                state    <= ST_RUN;
                hold_cnt <= 3'd0;
            end else begin
                hold_cnt <= hold_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mepc         <= 32'd0;
            mcause       <= 32'd0;
            mtvec        <= MTVEC_RESET & ADDR_MASK;
        end else if (x_trap_o) begin
            mepc         <= x_pc_i & ADDR_MASK;
            mcause       <= trap_cause;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (x_mret_o) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (csr_write) begin
            case (d_csr_sel_i)
                CSR_ID_MSTATUS: begin
                    mstatus_mie  <= x_csr_write_value_i[MSTATUS_MIE];
                    mstatus_mpie <= x_csr_write_value_i[MSTATUS_MPIE];
                end
                CSR_ID_MIE: begin
                    mie_mtie <= x_csr_write_value_i[MIP_MTIP];
                    mie_meie <= x_csr_write_value_i[MIP_MEIP];
                end
                CSR_ID_MTVEC:  mtvec  <= x_csr_write_value_i & ADDR_MASK;
                CSR_ID_MEPC:   mepc   <= x_csr_write_value_i & ADDR_MASK;
                CSR_ID_MCAUSE: mcause <= x_csr_write_value_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_mstatus_o               = MSTATUS_RESET;
        csr_mstatus_o[MSTATUS_MIE]  = mstatus_mie;
        csr_mstatus_o[MSTATUS_MPIE] = mstatus_mpie;

        csr_mie_o                   = 32'd0;
        csr_mie_o[MIP_MTIP]         = mie_mtie;
        csr_mie_o[MIP_MEIP]         = mie_meie;

        csr_mip_o                   = 32'd0;
        csr_mip_o[MIP_MTIP]         = mtip;
        csr_mip_o[MIP_MEIP]         = meip;
    end

    assign csr_mepc_o   = mepc;
    assign csr_mcause_o = mcause;
    assign csr_mtvec_o  = mtvec;

endmodule

// File: tb/tb_urv_exception_unit.sv
// Directed plus randomized bench for urv_exception_unit against a cycle-level behavioural model.
module tb_urv_exception_unit;
    import urv_exception_unit_pkg::*;

    localparam int          HOLDOFF   = 2;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0008;
`ifdef URV_EXT_IRQ_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        x_stall_i, x_kill_i, x_valid_i;
    logic [31:0] x_pc_i;
    logic        x_exception_i;
    logic [3:0]  x_exception_cause_i;
    logic        d_is_csr_i;
    logic [11:0] d_csr_sel_i;
    logic [31:0] x_csr_write_value_i;
    logic        d_is_mret_i;
    logic        irq_ext_i, timer_tick_i;
    logic        x_trap_o, x_mret_o;
    logic [31:0] x_redirect_pc_o;
    logic [31:0] csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o, csr_mtvec_o;

    int checks = 0;
    int errors = 0;

    urv_exception_unit #(.MTVEC_RESET(MTVEC_RST), .HOLDOFF_CYCLES(HOLDOFF)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .x_stall_i           (x_stall_i),
        .x_kill_i            (x_kill_i),
        .x_valid_i           (x_valid_i),
        .x_pc_i              (x_pc_i),
        .x_exception_i       (x_exception_i),
        .x_exception_cause_i (x_exception_cause_i),
        .d_is_csr_i          (d_is_csr_i),
        .d_csr_sel_i         (d_csr_sel_i),
        .x_csr_write_value_i (x_csr_write_value_i),
        .d_is_mret_i         (d_is_mret_i),
        .irq_ext_i           (irq_ext_i),
        .timer_tick_i        (timer_tick_i),
        .x_trap_o            (x_trap_o),
        .x_mret_o            (x_mret_o),
        .x_redirect_pc_o     (x_redirect_pc_o),
        .csr_mstatus_o       (csr_mstatus_o),
        .csr_mip_o           (csr_mip_o),
        .csr_mie_o           (csr_mie_o),
        .csr_mepc_o          (csr_mepc_o),
        .csr_mcause_o        (csr_mcause_o),
        .csr_mtvec_o         (csr_mtvec_o)
    );

    always #5 clk_i = ~clk_i;

    // Architectural model state
    bit          m_known = 1'b0;
    bit          m_ie, m_pie, m_tie, m_eie, m_timer;
    bit [31:0]   m_epc, m_cause, m_tvec;
    int          m_hold;
    bit [1:0]    m_hist;

    // Per-cycle model predictions
    bit          e_trap, e_mret, e_csr, e_mti;
    bit [31:0]   e_cause, e_redirect, e_mstatus, e_mie, e_mip;

    logic [11:0] sel_tab [7] = '{CSR_ID_MSTATUS, CSR_ID_MIE, CSR_ID_MTVEC, CSR_ID_MEPC,
                                 CSR_ID_MCAUSE, CSR_ID_MIP, 12'h7C0};
    logic [3:0]  cause_tab [4] = '{CAUSE_MISALIGN, CAUSE_ILLEGAL, CAUSE_EBREAK, CAUSE_ECALL};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit meip, commit, ext_on, tim_on, pend;
        meip    = SYNC ? m_hist[1] : irq_ext_i;
        commit  = x_valid_i && !x_stall_i && !x_kill_i;
        ext_on  = meip && m_eie;
        tim_on  = m_timer && m_tie;
        pend    = m_ie && (ext_on || tim_on) && (m_hold == 0);
        e_trap  = commit && (x_exception_i || pend);
        e_mret  = commit && d_is_mret_i && !e_trap;
        e_csr   = commit && d_is_csr_i && !e_trap;
        e_mti   = e_trap && !x_exception_i && !ext_on;
        if (x_exception_i) e_cause = 32'(x_exception_cause_i);
        else if (ext_on)   e_cause = 32'h8000_000B;
        else               e_cause = 32'h8000_0007;
        e_redirect = e_trap ? m_tvec : m_epc;
        e_mstatus  = 32'h1800 + (m_ie ? 32'h8 : 32'h0) + (m_pie ? 32'h80 : 32'h0);
        e_mie      = (m_tie ? 32'h80 : 32'h0) + (m_eie ? 32'h800 : 32'h0);
        e_mip      = (m_timer ? 32'h80 : 32'h0) + (meip ? 32'h800 : 32'h0);
    endtask

    task automatic model_update();
        if (!rst_i) begin
            m_known = 1'b1;
            m_ie = 0; m_pie = 0; m_tie = 0; m_eie = 0; m_timer = 0;
            m_epc = 0; m_cause = 0; m_tvec = MTVEC_RST & ~32'h3;
            m_hold = 0; m_hist = 2'b00;
            return;
        end
        m_hist  = {m_hist[0], irq_ext_i};
        m_timer = timer_tick_i || (m_timer && !e_mti);
        if (e_trap || e_mret) m_hold = HOLDOFF;
        else if (m_hold > 0)  m_hold = m_hold - 1;
        if (e_trap) begin
            m_epc = x_pc_i & ~32'h3;
            m_cause = e_cause;
            m_pie = m_ie;
            m_ie = 0;
        end else if (e_mret) begin
            m_ie = m_pie;
            m_pie = 1;
        end else if (e_csr) begin
            if (d_csr_sel_i == CSR_ID_MSTATUS) begin
                m_ie = x_csr_write_value_i[3];
                m_pie = x_csr_write_value_i[7];
            end else if (d_csr_sel_i == CSR_ID_MIE) begin
                m_tie = x_csr_write_value_i[7];
                m_eie = x_csr_write_value_i[11];
            end else if (d_csr_sel_i == CSR_ID_MTVEC)  m_tvec  = x_csr_write_value_i & ~32'h3;
            else if (d_csr_sel_i == CSR_ID_MEPC)       m_epc   = x_csr_write_value_i & ~32'h3;
            else if (d_csr_sel_i == CSR_ID_MCAUSE)     m_cause = x_csr_write_value_i;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
        if (m_known) begin
            chk("trap",     32'(x_trap_o),   32'(e_trap));
            chk("mret",     32'(x_mret_o),   32'(e_mret));
            chk("redirect", x_redirect_pc_o, e_redirect);
            chk("mstatus",  csr_mstatus_o,   e_mstatus);
            chk("mie",      csr_mie_o,       e_mie);
            chk("mip",      csr_mip_o,       e_mip);
            chk("mepc",     csr_mepc_o,      m_epc);
            chk("mcause",   csr_mcause_o,    m_cause);
            chk("mtvec",    csr_mtvec_o,     m_tvec);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic idle();
        x_valid_i = 0; x_stall_i = 0; x_kill_i = 0; x_exception_i = 0;
        d_is_csr_i = 0; d_is_mret_i = 0; timer_tick_i = 0;
    endtask

    task automatic instr(input logic [31:0] pc);
        idle();
        x_valid_i = 1; x_pc_i = pc;
    endtask

    task automatic csrw(input logic [11:0] sel, input logic [31:0] val);
        instr(32'h40);
        d_is_csr_i = 1; d_csr_sel_i = sel; x_csr_write_value_i = val;
    endtask

    task automatic mret_op();
        instr(32'h44);
        d_is_mret_i = 1;
    endtask

    initial begin
        rst_i = 0; irq_ext_i = 0; x_pc_i = 0; x_exception_cause_i = 0;
        d_csr_sel_i = 0; x_csr_write_value_i = 0;
        idle();
        @(negedge clk_i);

        // T1: reset
        repeat (3) cycle();
        rst_i = 1;
        settle();
        chk("t1_mstatus", csr_mstatus_o, 32'h1800);
        chk("t1_mtvec",   csr_mtvec_o,   32'h8);
        chk("t1_mcause",  csr_mcause_o,  32'h0);
        chk("t1_trap",    32'(x_trap_o), 32'h0);
        tick();

        // T2: ecall with MIE set
        csrw(CSR_ID_MSTATUS, 32'h8); cycle();
        instr(32'h100); x_exception_i = 1; x_exception_cause_i = CAUSE_ECALL;
        settle();
        chk("t2_trap",     32'(x_trap_o),   32'h1);
        chk("t2_redirect", x_redirect_pc_o, 32'h8);
        tick();
        chk("t2_mepc",    csr_mepc_o,    32'h100);
        chk("t2_mcause",  csr_mcause_o,  32'hB);
        chk("t2_mstatus", csr_mstatus_o, 32'h1880);
        idle(); repeat (2) cycle();

        // T3: simultaneous MEI and MTI
        mret_op();
        settle();
        chk("t3_mret",     32'(x_mret_o),   32'h1);
        chk("t3_mret_pc",  x_redirect_pc_o, 32'h100);
        tick();
        idle(); repeat (2) cycle();
        csrw(CSR_ID_MIE, 32'h880); cycle();
        idle(); irq_ext_i = 1; timer_tick_i = 1; cycle();
        idle(); repeat (3) cycle();
        instr(32'h200);
        settle();
        chk("t3_mei_trap", 32'(x_trap_o), 32'h1);
        tick();
        chk("t3_mei_cause", csr_mcause_o,  32'h8000_000B);
        chk("t3_mtip_kept", csr_mip_o[7],  32'h1);
        idle(); irq_ext_i = 0; repeat (2) cycle();
        mret_op(); cycle();
        idle(); repeat (2) cycle();
        instr(32'h300);
        settle();
        chk("t3_mti_trap", 32'(x_trap_o), 32'h1);
        tick();
        chk("t3_mti_cause", csr_mcause_o, 32'h8000_0007);
        chk("t3_mip_clear", csr_mip_o,    32'h0);

        // T4: exception beats a pending interrupt; interrupt after mret + holdoff
        idle(); repeat (2) cycle();
        mret_op(); cycle();
        idle(); irq_ext_i = 1; repeat (3) cycle();
        instr(32'h400); x_exception_i = 1; x_exception_cause_i = CAUSE_ILLEGAL;
        cycle();
        chk("t4_exc_cause", csr_mcause_o, 32'h2);
        idle(); repeat (2) cycle();
        mret_op(); cycle();
        instr(32'h500); settle(); chk("t4_hold1", 32'(x_trap_o), 32'h0); tick();
        instr(32'h504); settle(); chk("t4_hold2", 32'(x_trap_o), 32'h0); tick();
        instr(32'h508); settle(); chk("t4_irq",   32'(x_trap_o), 32'h1); tick();
        chk("t4_irq_cause", csr_mcause_o, 32'h8000_000B);
        chk("t4_irq_mepc",  csr_mepc_o,   32'h508);
        idle(); irq_ext_i = 0; repeat (2) cycle();

        // T5: CSR write suppressed by a same-cycle trap, then deferred by stall
        csrw(CSR_ID_MSTATUS, 32'h8); x_exception_i = 1; x_exception_cause_i = CAUSE_ILLEGAL;
        cycle();
        chk("t5_suppressed", csr_mstatus_o, 32'h1800);
        idle(); repeat (3) cycle();
        csrw(CSR_ID_MSTATUS, 32'h8); x_stall_i = 1;
        cycle(); chk("t5_stall1", csr_mstatus_o, 32'h1800);
        cycle(); chk("t5_stall2", csr_mstatus_o, 32'h1800);
        x_stall_i = 0;
        cycle(); chk("t5_written", csr_mstatus_o, 32'h1808);

        // Reset in the middle of HOLD drops the pending timer
        idle(); timer_tick_i = 1; cycle();
        instr(32'h600); x_exception_i = 1; x_exception_cause_i = CAUSE_EBREAK; cycle();
        idle(); rst_i = 0; cycle();
        rst_i = 1;
        settle();
        chk("rst_mip",     csr_mip_o,     32'h0);
        chk("rst_mstatus", csr_mstatus_o, 32'h1800);
        tick();

        // T6: MEIP latency
        idle(); irq_ext_i = 1;
        settle(); chk("t6_meip_c0", 32'(csr_mip_o[11]), SYNC ? 32'h0 : 32'h1); tick();
        settle(); chk("t6_meip_c1", 32'(csr_mip_o[11]), SYNC ? 32'h0 : 32'h1); tick();
        settle(); chk("t6_meip_c2", 32'(csr_mip_o[11]), 32'h1); tick();
        irq_ext_i = 0; cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int kind;
            idle();
            rst_i     = ($urandom_range(0, 99) != 0);
            x_valid_i = ($urandom_range(0, 3) != 0);
            x_stall_i = ($urandom_range(0, 4) == 0);
            x_kill_i  = ($urandom_range(0, 7) == 0);
            x_pc_i    = $urandom;
            kind      = $urandom_range(0, 7);
            if (kind == 2) begin
                x_exception_i = 1;
                x_exception_cause_i = cause_tab[$urandom_range(0, 3)];
            end else if (kind == 3 || kind == 4) begin
                d_is_csr_i = 1;
                d_csr_sel_i = sel_tab[$urandom_range(0, 6)];
                x_csr_write_value_i = ($urandom_range(0, 1) != 0) ? $urandom : 32'h888;
            end else if (kind == 5) begin
                d_is_mret_i = 1;
            end
            if ($urandom_range(0, 11) == 0) irq_ext_i = ~irq_ext_i;
            timer_tick_i = ($urandom_range(0, 11) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
